conv_seq_ctrl: RTL

Frame sequencer and coefficient manager for the 3x3 RGB convolution datapath (`conv`). It holds the 27 signed 4-bit kernel coefficients in a double-buffered bank, so host writes never change coefficients mid-frame. It gates the pixel stream into `conv` over one IMG_W x IMG_H frame and counts `conv` output beats to detect frame completion or a drain timeout. It sits between the host/config bus, the pixel source and `conv`.

---
 rtl/conv_seq_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer and double-buffered coefficient manager for the 3x3 RGB conv datapath.
// Gates one IMG_W x IMG_H frame into conv and counts its output beats for completion/timeout.
module conv_seq_ctrl #(
  parameter int IMG_W     = 480,
  parameter int IMG_H     = 272,
  parameter int EXP_OUT   = IMG_W * (IMG_H - 2),
  parameter int DRAIN_TMO = 1024,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H),
  localparam int OW = $clog2(EXP_OUT + 1),
  localparam int TW = $clog2(DRAIN_TMO + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_addr,
  input  logic [3:0]    cfg_wdata,
  input  logic          cfg_commit,
  input  logic          src_valid,
  output logic          src_ready,
  output logic          conv_data_in_en,
  input  logic          conv_data_out_en,
  output logic [35:0]   coe_r,
  output logic [35:0]   coe_g,
  output logic [35:0]   coe_b,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          busy,
  output logic          cfg_pending,
  output logic          frame_done,
  output logic          timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [35:0] IDENT = 36'h000010000;

  state_e          state_q;
  logic [26:0][3:0] shadow_q;
  logic [26:0][3:0] active_q;
  logic            cfg_pending_q;
  logic            src_ready_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            timeout_err_q;
  logic [XW-1:0]   pix_x_q;
  logic [YW-1:0]   pix_y_q;
  logic [OW-1:0]   out_cnt_q;
  logic [TW-1:0]   tmo_cnt_q;

  logic beat;
  logic out_beat;
  logic last_x;
  logic last_y;
  logic out_full;

  assign beat     = src_valid & src_ready_q;
  assign out_beat = conv_data_out_en & ((state_q == S_RUN) | (state_q == S_DRAIN));
  assign last_x   = (pix_x_q == XW'(IMG_W - 1));
  assign last_y   = (pix_y_q == YW'(IMG_H - 1));
  assign out_full = (out_cnt_q == OW'(EXP_OUT));

  // Shadow bank takes host writes in any state; LOAD copies the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= {3{IDENT}};
    end else if (cfg_we && (cfg_addr < 5'd27)) begin
      shadow_q[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      active_q      <= {3{IDENT}};
      cfg_pending_q <= 1'b0;
      src_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      out_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      if (cfg_commit) cfg_pending_q <= 1'b1;
      if (abort && (state_q != S_IDLE)) begin
        // Abort keeps both banks and any pending commit untouched.
        state_q      <= S_IDLE;
        src_ready_q  <= 1'b0;
        busy_q       <= 1'b0;
        frame_done_q <= 1'b0;
        pix_x_q      <= '0;
        pix_y_q      <= '0;
        out_cnt_q    <= '0;
        tmo_cnt_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_LOAD;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (cfg_pending_q || cfg_commit) begin
              active_q      <= shadow_q;
              cfg_pending_q <= 1'b0;
            end
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            out_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            src_ready_q   <= 1'b1;
            state_q       <= S_RUN;
          end
          S_RUN: begin
            if (out_beat && !out_full) out_cnt_q <= out_cnt_q + 1'b1;
            if (beat) begin
              if (last_x) begin
                pix_x_q <= '0;
                if (last_y) begin
                  state_q     <= S_DRAIN;
                  src_ready_q <= 1'b0;
                end else begin
                  pix_y_q <= pix_y_q + 1'b1;
                end
              end else begin
                pix_x_q <= pix_x_q + 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (out_beat && !out_full) out_cnt_q <= out_cnt_q + 1'b1;
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            // Completion wins over a timeout landing in the same cycle.
            if (out_full) begin
              state_q      <= S_DONE;
              frame_done_q <= 1'b1;
            end else if (tmo_cnt_q == TW'(DRAIN_TMO - 1)) begin
              state_q       <= S_DONE;
              frame_done_q  <= 1'b1;
              timeout_err_q <= 1'b1;
            end
          end
          S_DONE: begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
          end
          default: begin
            state_q      <= S_IDLE;
            src_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign src_ready       = src_ready_q;
  assign conv_data_in_en = beat;
  assign coe_r           = active_q[8:0];
  assign coe_g           = active_q[17:9];
  assign coe_b           = active_q[26:18];
  assign pix_x           = pix_x_q;
  assign pix_y           = pix_y_q;
  assign busy            = busy_q;
  assign cfg_pending     = cfg_pending_q;
  assign frame_done      = frame_done_q;
  assign timeout_err     = timeout_err_q;

endmodule
